// File: rtl/ula_multdiv.sv
// Iterative MIPS HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, with architectural HI/LO registers.
module ula_multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             erro,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t             state_r, state_s;
  logic [5:0]         op_r;
  logic [WIDTH-1:0]   a_r, b_r, d_r, q_r;
  logic [WIDTH:0]     r_r;
  logic [CW-1:0]      cnt_r;
  logic               neg_q_r, neg_r_r;

  logic               idle_start_s, is_md_s, is_div_s, div0_s;
  logic               accept_md_s, accept_mthi_s, accept_mtlo_s;
  logic               op_mul_s, op_signed_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, quo_fix_s, rem_fix_s;
  logic [WIDTH:0]     add_s, sh_s, diff_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;

  // Request decode; only an IDLE unit looks at start.
  always_comb begin
    idle_start_s  = start && (state_r == IDLE);
    is_div_s      = (funct == F_DIV) || (funct == F_DIVU);
    is_md_s       = (funct == F_MULT) || (funct == F_MULTU) || is_div_s;
    div0_s        = idle_start_s && is_div_s && (b == {WIDTH{1'b0}});
    accept_md_s   = idle_start_s && is_md_s && !div0_s;
    accept_mthi_s = idle_start_s && (funct == F_MTHI);
    accept_mtlo_s = idle_start_s && (funct == F_MTLO);
  end

  // Per-step arithmetic on the latched operation.
  always_comb begin
    op_mul_s    = (op_r == F_MULT) || (op_r == F_MULTU);
    op_signed_s = (op_r == F_MULT) || (op_r == F_DIV);
    if (op_signed_s && a_r[WIDTH-1]) mag_a_s = -a_r;
    else                             mag_a_s = a_r;
    if (op_signed_s && b_r[WIDTH-1]) mag_b_s = -b_r;
    else                             mag_b_s = b_r;
    if (q_r[0]) add_s = {1'b0, r_r[WIDTH-1:0]} + {1'b0, d_r};
    else        add_s = {1'b0, r_r[WIDTH-1:0]};
    sh_s   = {r_r[WIDTH-1:0], q_r[WIDTH-1]};
    diff_s = sh_s - {1'b0, d_r};
    prod_s = {r_r[WIDTH-1:0], q_r};
    if (neg_q_r) begin
      prod_fix_s = -prod_s;
      quo_fix_s  = -q_r;
    end else begin
      prod_fix_s = prod_s;
      quo_fix_s  = q_r;
    end
    if (neg_r_r) rem_fix_s = -r_r[WIDTH-1:0];
    else         rem_fix_s = r_r[WIDTH-1:0];
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_md_s) state_s = PREP;
        else             state_s = IDLE;
      end
      PREP: state_s = CALC;
      CALC: begin
        if (cnt_r == CNT_ONE) state_s = FIX;
        else                  state_s = CALC;
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Datapath, handshake and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      erro    <= 1'b0;
      hi      <= {WIDTH{1'b0}};
      lo      <= {WIDTH{1'b0}};
      op_r    <= 6'd0;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      d_r     <= {WIDTH{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      r_r     <= {(WIDTH+1){1'b0}};
      cnt_r   <= {CW{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else begin
      busy <= (state_s != IDLE);
      done <= div0_s || accept_mthi_s || accept_mtlo_s || (state_r == FIX);
      if (div0_s)
        erro <= 1'b1;
      else if (accept_md_s || accept_mthi_s || accept_mtlo_s)
        erro <= 1'b0;
      else
        erro <= erro;
      if (accept_md_s) begin
        op_r <= funct;
        a_r  <= a;
        b_r  <= b;
      end
      case (state_r)
        PREP: begin
          q_r     <= mag_a_s;
          d_r     <= mag_b_s;
          r_r     <= {(WIDTH+1){1'b0}};
          cnt_r   <= CNT_LOAD;
          neg_q_r <= op_signed_s && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          neg_r_r <= op_signed_s && a_r[WIDTH-1];
        end
        CALC: begin
          cnt_r <= cnt_r - CNT_ONE;
          if (op_mul_s) begin
            r_r <= {1'b0, add_s[WIDTH:1]};
            q_r <= {add_s[0], q_r[WIDTH-1:1]};
          end else if (!diff_s[WIDTH]) begin
            r_r <= diff_s;
            q_r <= {q_r[WIDTH-2:0], 1'b1};
          end else begin
            r_r <= sh_s;
            q_r <= {q_r[WIDTH-2:0], 1'b0};
          end
        end
        default: begin
        end
      endcase
      // Divide writes quotient to LO and remainder to HI.
      if (state_r == FIX) begin
        if (op_mul_s) begin
          hi <= prod_fix_s[2*WIDTH-1:WIDTH];
          lo <= prod_fix_s[WIDTH-1:0];
        end else begin
          hi <= rem_fix_s;
          lo <= quo_fix_s;
        end
      end else if (accept_mthi_s) begin
        hi <= a;
      end else if (accept_mtlo_s) begin
        lo <= a;
      end else begin
        hi <= hi;
        lo <= lo;
      end
    end
  end
endmodule
